pipe_ctrl: RTL and testbench

- Parametrised pipeline sequencer for the RISC-V core.
- Owns the PC, per-stage valid bits and per-stage load enables for a STAGES-deep in-order pipeline.
- Arbitrates hold (stall) and flush/redirect requests from any stage, so the top level no longer hand-codes stall/flush priority per register.
- Sits beside the datapath. Each pipeline register loads when its stage_en bit is high.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_prio_enc.sv | 23 ++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stage indices, PC step, counter width.
package pipe_ctrl_pkg;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  localparam int unsigned PC_STEP = 4;
  localparam int unsigned PERF_W  = 32;

endpackage

// File: rtl/pipe_prio_enc.sv
// Highest-set-bit priority encoder: found=1 and idx=index of the top set bit of req.
module pipe_prio_enc #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns fetch PC, per-stage valid bits and per-stage load
// enables; arbitrates hold and flush/redirect requests from any stage.
// Optional performance counters: define PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int              STAGES   = 5,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STAGES-1:0]      hold_req,
  input  logic [STAGES-1:0]      flush_req,
  input  logic [STAGES*PC_W-1:0] flush_tgt,
  output logic [PC_W-1:0]        pc,
  output logic [STAGES-1:0]      stage_valid,
  output logic [STAGES-1:0]      stage_en,
  output logic                   fetch_kill,
  output logic                   redirect,
  output logic [PERF_W-1:0]      perf_retire,
  output logic [PERF_W-1:0]      perf_stall,
  output logic [PERF_W-1:0]      perf_flush
);

  localparam int SIDX_W = $clog2(STAGES);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] h, fl, en;
  logic              s_found, f_found;
  logic [SIDX_W-1:0] s_idx, f_idx;
  logic              flush_acc;
  logic [PC_W-1:0]   pc_q, pc_d, tgt;
  logic              redirect_q, fetch_kill_q;

  assign h  = hold_req  & valid_q;
  assign fl = flush_req & valid_q;

  pipe_prio_enc #(.N(STAGES), .W(SIDX_W)) u_hold_enc (
    .req   (h),
    .found (s_found),
    .idx   (s_idx)
  );

  pipe_prio_enc #(.N(STAGES), .W(SIDX_W)) u_flush_enc (
    .req   (fl),
    .found (f_found),
    .idx   (f_idx)
  );

  // A flush wins only when strictly older than every held stage.
  assign flush_acc = f_found && (!s_found || (f_idx > s_idx));

  // Stages at or below the oldest hold freeze; everything older advances.
  always_comb begin
    en = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      en[i] = !s_found || (SIDX_W'(i) > s_idx);
    end
  end

  // Select the redirect target slice of the oldest accepted flusher.
  always_comb begin
    tgt = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (SIDX_W'(i) == f_idx) tgt = flush_tgt[i*PC_W +: PC_W];
    end
  end

  // Next valid bits: flush kill, then bubble behind a hold, then normal shift.
  // The bubble stage is the first enabled stage directly above a frozen one.
  always_comb begin
    valid_d         = valid_q;
    valid_d[STG_IF] = 1'b1;
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (flush_acc && (SIDX_W'(i) <= f_idx)) begin
        valid_d[i] = 1'b0;
      end else if (en[i] && !en[i-1]) begin
        valid_d[i] = 1'b0;
      end else if (en[i]) begin
        if (i == STG_ID) valid_d[i] = valid_q[STG_IF] & ~fetch_kill_q;
        else             valid_d[i] = valid_q[i-1];
      end
    end
  end

  // Next PC: redirect overrides a stage-0 hold; otherwise step or hold.
  always_comb begin
    if (flush_acc)       pc_d = tgt;
    else if (en[STG_IF]) pc_d = pc_q + PC_W'(PC_STEP);
    else                 pc_d = pc_q;
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      valid_q      <= '0;
      redirect_q   <= 1'b0;
      fetch_kill_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      redirect_q   <= flush_acc;
      fetch_kill_q <= flush_acc;
    end
  end

  assign pc          = pc_q;
  assign stage_valid = valid_q;
  assign stage_en    = en;
  assign redirect    = redirect_q;
  assign fetch_kill  = fetch_kill_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] retire_q, stall_q, flush_q;

  // Retire, stall and flush event counters; wrap naturally at 2^PERF_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      if (valid_q[STAGES-1] && en[STAGES-1]) retire_q <= retire_q + 1'b1;
      if (s_found)                           stall_q  <= stall_q + 1'b1;
      if (flush_acc)                         flush_q  <= flush_q + 1'b1;
    end
  end

  assign perf_retire = retire_q;
  assign perf_stall  = stall_q;
  assign perf_flush  = flush_q;
`else
  assign perf_retire = '0;
  assign perf_stall  = '0;
  assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (STAGES=5, PC_W=32, RESET_PC=0x100).
module tb_pipe_ctrl;

  localparam int S = 5;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [S-1:0]   hold_req;
  logic [S-1:0]   flush_req;
  logic [S*W-1:0] flush_tgt;
  logic [W-1:0]   pc;
  logic [S-1:0]   stage_valid;
  logic [S-1:0]   stage_en;
  logic           fetch_kill;
  logic           redirect;
  logic [31:0]    perf_retire, perf_stall, perf_flush;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_ctrl #(.STAGES(S), .PC_W(W), .RESET_PC(32'h100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold_req    (hold_req),
    .flush_req   (flush_req),
    .flush_tgt   (flush_tgt),
    .pc          (pc),
    .stage_valid (stage_valid),
    .stage_en    (stage_en),
    .fetch_kill  (fetch_kill),
    .redirect    (redirect),
    .perf_retire (perf_retire),
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_perf(input string tag, input int r, input int st, input int fc);
`ifdef PIPE_CTRL_PERF_CNT_EN
    check({tag, " retire"}, 64'(perf_retire), 64'(r));
    check({tag, " stall"},  64'(perf_stall),  64'(st));
    check({tag, " flush"},  64'(perf_flush),  64'(fc));
`else
    check({tag, " retire"}, 64'(perf_retire), 64'(0));
    check({tag, " stall"},  64'(perf_stall),  64'(0));
    check({tag, " flush"},  64'(perf_flush),  64'(0));
    if (r + st + fc < 0) $display("unused");
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] epc, input logic [4:0] ev,
                           input logic erd, input logic efk);
    check({tag, " pc"},       64'(pc),          64'(epc));
    check({tag, " valid"},    64'(stage_valid), 64'(ev));
    check({tag, " redirect"}, 64'(redirect),    64'(erd));
    check({tag, " fkill"},    64'(fetch_kill),  64'(efk));
  endtask

  logic [4:0] fill_v [1:5];

  initial begin
    fill_v[1] = 5'b00001; fill_v[2] = 5'b00011; fill_v[3] = 5'b00111;
    fill_v[4] = 5'b01111; fill_v[5] = 5'b11111;

    rst_n = 1'b0; hold_req = '0; flush_req = '0; flush_tgt = '0;
    tick(); tick();
    chk_state("reset", 32'h100, 5'b00000, 1'b0, 1'b0);
    check("reset en", 64'(stage_en), 64'(5'b11111));
    check_perf("reset", 0, 0, 0);
    rst_n = 1'b1;

    // Fill: one new valid stage per clock, PC steps by 4.
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_state($sformatf("fill%0d", k), 32'h100 + 32'(4*k), fill_v[k], 1'b0, 1'b0);
    end
    tick();
    chk_state("fill6", 32'h118, 5'b11111, 1'b0, 1'b0);
    check_perf("fill6", 1, 0, 0);

    // Hold at stage 2: upper two stages advance, bubble into stage 3.
    hold_req = 5'b00100;
    #1;
    check("hold2 en", 64'(stage_en), 64'(5'b11000));
    tick();
    hold_req = '0;
    chk_state("hold2", 32'h118, 5'b10111, 1'b0, 1'b0);
    check_perf("hold2", 2, 1, 0);
    tick();
    chk_state("hold2+1", 32'h11C, 5'b01111, 1'b0, 1'b0);
    tick();
    chk_state("hold2+2", 32'h120, 5'b11111, 1'b0, 1'b0);

    // Flush from stage 2 to 0x200.
    flush_req = 5'b00100;
    flush_tgt[2*W +: W] = 32'h200;
    tick();
    flush_req = '0;
    chk_state("flush2", 32'h200, 5'b11001, 1'b1, 1'b1);
    check_perf("flush2", 4, 1, 1);
    tick();
    chk_state("flush2+1", 32'h204, 5'b10001, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    chk_state("refill", 32'h214, 5'b11111, 1'b0, 1'b0);
    check_perf("refill", 6, 1, 1);

    // Two flushes at once: the older one (stage 2) wins.
    flush_req = 5'b00110;
    flush_tgt[1*W +: W] = 32'h300;
    flush_tgt[2*W +: W] = 32'h400;
    tick();
    flush_req = '0;
    chk_state("dual", 32'h400, 5'b11001, 1'b1, 1'b1);
    tick();
    chk_state("dual+1", 32'h404, 5'b10001, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    chk_state("refill2", 32'h414, 5'b11111, 1'b0, 1'b0);
    check_perf("refill2", 9, 1, 2);

    // Hold at 3 blocks a younger flush at 2; released hold lets it through.
    hold_req = 5'b01000;
    flush_req = 5'b00100;
    flush_tgt[2*W +: W] = 32'h500;
    #1;
    check("blk en", 64'(stage_en), 64'(5'b10000));
    tick();
    chk_state("blocked", 32'h414, 5'b01111, 1'b0, 1'b0);
    hold_req = '0;
    tick();
    flush_req = '0;
    chk_state("unblocked", 32'h500, 5'b11001, 1'b1, 1'b1);
    check_perf("unblocked", 10, 2, 3);

    // Hold on the last stage freezes everything without a bubble.
    hold_req = 5'b10000;
    #1;
    check("last en", 64'(stage_en), 64'(5'b00000));
    tick();
    chk_state("lasthold", 32'h500, 5'b11001, 1'b0, 1'b0);
    check_perf("lasthold", 10, 3, 3);

    // Requests from an invalid stage (stage 2) are ignored.
    hold_req = 5'b00100;
    flush_req = 5'b00100;
    #1;
    check("inval en", 64'(stage_en), 64'(5'b11111));
    tick();
    chk_state("invalreq", 32'h504, 5'b10011, 1'b0, 1'b0);

    // Hold and flush at the same stage: hold wins.
    hold_req = 5'b00001;
    flush_req = 5'b00001;
    #1;
    check("same en", 64'(stage_en), 64'(5'b11110));
    tick();
    chk_state("samestg", 32'h504, 5'b00101, 1'b0, 1'b0);
    check_perf("samestg", 12, 4, 3);

    // Asynchronous reset mid-stream with requests still active.
    hold_req = 5'b01000;
    flush_req = 5'b00010;
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("midreset", 32'h100, 5'b00000, 1'b0, 1'b0);
    check_perf("midreset", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
